// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory port, branch redirect and IF/ID handshake.
// The fetch unit is the master; memory, branch unit and decode together form the slave.
interface fetch_unit_if;
    logic [63:0] busPc;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [63:0] if_pc;

    modport master (
        output busPc, if_valid, if_instr, if_pc,
        input  instruction, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  busPc, if_valid, if_instr, if_pc,
        output instruction, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc to instruction memory and fills a one-entry IF/ID register
// drained by decode over valid/ready; supports start gating, redirect/flush and halt on zero word.
module fetch_unit #(
    parameter logic [63:0] RESET_PC     = 64'h0,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    fetch_unit_if.master        bus,
    output logic                halted,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] ipc_q, ipc_d;
    logic [31:0] count_q, count_d;

    logic fire;
    logic slot_free;
    logic halt_word;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;

        fire      = valid_q && bus.if_ready;
        slot_free = !valid_q || bus.if_ready;
        halt_word = HALT_ON_ZERO && (bus.instruction == 32'h0);
        count_d   = count_q + {31'b0, fire};

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StRun;
            end
            StRun: begin
                if (slot_free) begin
                    if (halt_word) begin
                        // Slot is free here, so the old entry is either absent or leaving now.
                        state_d = StHalt;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = bus.instruction;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 64'd4;
                    end
                end
            end
            StHalt: begin
                if (fire) valid_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // Redirect overrides any capture this cycle; the in-flight fetch is dropped.
        if (state_q != StIdle && bus.redirect_valid) begin
            pc_d    = bus.redirect_pc & ~64'h3;
            valid_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            ipc_q   <= 64'h0;
            count_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            count_q <= count_d;
        end
    end

    assign bus.busPc    = pc_q;
    assign bus.if_valid = valid_q;
    assign bus.if_instr = instr_q;
    assign bus.if_pc    = ipc_q;
    assign halted       = (state_q == StHalt);
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: program-order reference stream plus directed redirect,
// reset and wrap scenarios; inputs driven and outputs sampled on the falling edge.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halted;
    logic [31:0] fetch_count;

    fetch_unit_if bus();

    logic [31:0] mem [512];
    int n_checks = 0;
    int n_fail = 0;

    // Reference: the instruction stream a program should deliver, in order.
    logic [63:0] exp_pc [$];
    logic [63:0] got_pc [$];
    logic [31:0] got_in [$];

    assign bus.instruction = mem[bus.busPc[10:2]];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .bus         (bus),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic load_program();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[0] = 32'hF840_02A0;
        mem[1] = 32'hF840_02A1;
        mem[2] = 32'hF800_02A0;
        mem[3] = 32'hF800_02A1;
    endtask

    task automatic build_expect(input logic [63:0] from);
        logic [63:0] p;
        exp_pc.delete();
        p = from;
        while (mem[p[10:2]] != 32'h0 && exp_pc.size() < 512) begin
            exp_pc.push_back(p);
            p = p + 64'd4;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.if_ready = 1'b0;
        got_pc.delete();
        got_in.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compares the collected delivery stream against the reference stream.
    task automatic compare_stream(input string tag);
        n_checks++;
        if (got_pc.size() != exp_pc.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d deliveries, want %0d", tag, got_pc.size(), exp_pc.size());
        end
        for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== exp_pc[i] || got_in[i] !== mem[exp_pc[i][10:2]]) begin
                n_fail++;
                $display("FAIL %s_item%0d: got pc %h instr %h, want pc %h instr %h", tag, i,
                         got_pc[i], got_in[i], exp_pc[i], mem[exp_pc[i][10:2]]);
            end
        end
    endtask

    task automatic test_reset();
        load_program();
        do_reset();
        n_checks++;
        if (bus.busPc !== 64'h0 || bus.if_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got pc %h valid %b halted %b, want 0 0 0",
                     bus.busPc, bus.if_valid, halted);
        end
        n_checks++;
        if (bus.if_instr !== 32'h0 || bus.if_pc !== 64'h0 || fetch_count !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got instr %h if_pc %h count %0d, want 0 0 0",
                     bus.if_instr, bus.if_pc, fetch_count);
        end
        bus.if_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.busPc !== 64'h0) begin
            n_fail++;
            $display("FAIL idle_no_fetch: got valid %b pc %h, want 0 0", bus.if_valid, bus.busPc);
        end
    endtask

    task automatic test_program();
        int first;
        int c;
        load_program();
        do_reset();
        build_expect(64'h0);
        bus.if_ready = 1'b1;
        pulse_start();
        first = -1;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (halted) break;
            if (bus.if_valid && bus.if_ready) begin
                if (first < 0) first = c;
                n_checks++;
                if (c != first + got_pc.size()) begin
                    n_fail++;
                    $display("FAIL prog_throughput: delivery %0d at cycle %0d, want %0d",
                             got_pc.size(), c, first + got_pc.size());
                end
                got_pc.push_back(bus.if_pc);
                got_in.push_back(bus.if_instr);
            end
        end
        n_checks++;
        if (first != 0) begin
            n_fail++;
            $display("FAIL prog_latency: first delivery at cycle %0d, want 0", first);
        end
        compare_stream("prog");
        n_checks++;
        if (halted !== 1'b1 || bus.busPc !== 64'h10 || bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL prog_halt: got halted %b pc %h valid %b, want 1 10 0",
                     halted, bus.busPc, bus.if_valid);
        end
        n_checks++;
        if (fetch_count !== 32'(exp_pc.size())) begin
            n_fail++;
            $display("FAIL prog_count: got %0d, want %0d", fetch_count, exp_pc.size());
        end
    endtask

    task automatic test_stall();
        load_program();
        do_reset();
        build_expect(64'h0);
        bus.if_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.if_valid && bus.if_pc == 64'h4) break;
            if (bus.if_valid && bus.if_ready) begin
                got_pc.push_back(bus.if_pc);
                got_in.push_back(bus.if_instr);
            end
        end
        bus.if_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.if_instr !== 32'hF840_02A1 || bus.if_valid !== 1'b1 || bus.busPc !== 64'h8) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got instr %h valid %b pc %h, want F84002A1 1 8",
                         c, bus.if_instr, bus.if_valid, bus.busPc);
            end
        end
        bus.if_ready = 1'b1;
        for (int c = 0; c < 20 && !halted; c++) begin
            if (bus.if_valid && bus.if_ready) begin
                got_pc.push_back(bus.if_pc);
                got_in.push_back(bus.if_instr);
            end
            @(negedge clk);
        end
        compare_stream("stall");
        n_checks++;
        if (fetch_count !== 32'd4 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_end: got count %0d halted %b, want 4 1", fetch_count, halted);
        end
    endtask

    task automatic test_random_ready();
        logic        held;
        logic [63:0] hpc;
        logic [31:0] hin;
        load_program();
        do_reset();
        build_expect(64'h0);
        bus.if_ready = 1'b0;
        pulse_start();
        held = 1'b0;
        hpc = 64'h0;
        hin = 32'h0;
        for (int c = 0; c < 200 && !halted; c++) begin
            bus.if_ready = 1'($urandom_range(0, 1));
            held = bus.if_valid && !bus.if_ready;
            hpc = bus.if_pc;
            hin = bus.if_instr;
            if (bus.if_valid && bus.if_ready) begin
                got_pc.push_back(bus.if_pc);
                got_in.push_back(bus.if_instr);
            end
            @(negedge clk);
            if (held) begin
                n_checks++;
                if (bus.if_valid !== 1'b1 || bus.if_pc !== hpc || bus.if_instr !== hin) begin
                    n_fail++;
                    $display("FAIL rand_stable: got valid %b pc %h instr %h, want 1 %h %h",
                             bus.if_valid, bus.if_pc, bus.if_instr, hpc, hin);
                end
            end
        end
        compare_stream("rand");
        n_checks++;
        if (fetch_count !== 32'(exp_pc.size()) || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_end: got count %0d halted %b, want %0d 1",
                     fetch_count, halted, exp_pc.size());
        end
    endtask

    task automatic test_redirect_run();
        int hs;
        load_program();
        do_reset();
        bus.if_ready = 1'b1;
        pulse_start();
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.if_valid && bus.if_pc == 64'h8) break;
            if (bus.if_valid && bus.if_ready) hs++;
            @(negedge clk);
        end
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h0;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.busPc !== 64'h0) begin
            n_fail++;
            $display("FAIL redir_flush: got valid %b pc %h, want 0 0", bus.if_valid, bus.busPc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0 || bus.if_instr !== 32'hF840_02A0) begin
            n_fail++;
            $display("FAIL redir_target: got valid %b pc %h instr %h, want 1 0 F84002A0",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
        n_checks++;
        if (fetch_count !== 32'(hs)) begin
            n_fail++;
            $display("FAIL redir_count: got %0d, want %0d", fetch_count, hs);
        end
        // Redirect with a simultaneous accept: flushed, but the handshake still counts.
        bus.if_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h8;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (fetch_count !== 32'(hs + 1) || bus.if_valid !== 1'b0 || bus.busPc !== 64'h8) begin
            n_fail++;
            $display("FAIL redir_accept: got count %0d valid %b pc %h, want %0d 0 8",
                     fetch_count, bus.if_valid, bus.busPc, hs + 1);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_pc !== 64'h8 || bus.if_instr !== 32'hF800_02A0) begin
            n_fail++;
            $display("FAIL redir_accept_next: got pc %h instr %h, want 8 F80002A0",
                     bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_redirect_halt();
        load_program();
        do_reset();
        bus.if_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 20 && !halted; c++) @(negedge clk);
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reach: got halted %b, want 1", halted);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h6;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.busPc !== 64'h4 || halted !== 1'b0 || bus.if_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_redir: got pc %h halted %b valid %b, want 4 0 0",
                     bus.busPc, halted, bus.if_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_instr !== 32'hF840_02A1 || bus.if_pc !== 64'h4 || fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL halt_resume: got instr %h pc %h count %0d, want F84002A1 4 4",
                     bus.if_instr, bus.if_pc, fetch_count);
        end
    endtask

    task automatic test_async_reset();
        load_program();
        do_reset();
        bus.if_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.if_pc !== 64'h0 || bus.if_instr !== 32'h0 ||
            bus.busPc !== 64'h0 || fetch_count !== 32'h0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: got valid %b if_pc %h instr %h pc %h count %0d, want all 0",
                     bus.if_valid, bus.if_pc, bus.if_instr, bus.busPc, fetch_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h40;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.busPc !== 64'h0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_redir: got valid %b pc %h halted %b, want 0 0 0",
                     bus.if_valid, bus.busPc, halted);
        end
        pulse_start();
        @(negedge clk);
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 64'h0 || bus.if_instr !== 32'hF840_02A0) begin
            n_fail++;
            $display("FAIL rst_restart: got valid %b pc %h instr %h, want 1 0 F84002A0",
                     bus.if_valid, bus.if_pc, bus.if_instr);
        end
    endtask

    task automatic test_wrap();
        load_program();
        mem[511] = 32'h1234_5678;
        do_reset();
        bus.if_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.busPc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_redir: got valid %b pc %h, want 0 FFFFFFFFFFFFFFFC",
                     bus.if_valid, bus.busPc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || bus.if_instr !== 32'h1234_5678 ||
            bus.busPc !== 64'h0) begin
            n_fail++;
            $display("FAIL wrap_top: got if_pc %h instr %h pc %h, want FFFFFFFFFFFFFFFC 12345678 0",
                     bus.if_pc, bus.if_instr, bus.busPc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_pc !== 64'h0 || bus.if_instr !== 32'hF840_02A0) begin
            n_fail++;
            $display("FAIL wrap_zero: got if_pc %h instr %h, want 0 F84002A0",
                     bus.if_pc, bus.if_instr);
        end
    endtask

    initial begin
        bus.if_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        test_reset();
        test_program();
        test_stall();
        test_random_ready();
        test_redirect_run();
        test_redirect_halt();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1, "timeout");
    end

endmodule
